// File: rtl/prio_enc_seq.sv
// prio_enc_seq
//   Registered N:log2(N) request encoder. A request vector is accepted over a
//   valid/ready handshake into a pending register. The index of every set bit
//   is then emitted, one per output handshake, in fixed-priority (MODE=0) or
//   round-robin (MODE=1) order.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     req        in   N-bit request vector, bit i requests index i
//     req_valid  in   req is valid this cycle
//     req_ready  out  block can accept a vector (IDLE only)
//     idx        out  W-bit index of the current pending bit
//     out_valid  out  idx is valid
//     out_ready  in   consumer takes idx this cycle
//     out_last   out  idx is the final set bit of the current vector
//     zero_err   out  one-cycle pulse when an all-zero vector is accepted
module prio_enc_seq #(
    parameter int N    = 8,
    parameter int W    = 3,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         req_valid,
    output logic         req_ready,
    output logic [W-1:0] idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         zero_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [N-1:0] ONE      = N'(1);
    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [W-1:0]   idx_q, idx_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           zero_err_q, zero_err_d;

    logic [N-1:0]   rem;
    logic [W-1:0]   ptr_nxt;

    // Lowest-numbered set bit; scanning from the top lets the last hit win.
    function automatic logic [W-1:0] lowest(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[N-1-i]) r = W'(N - 1 - i);
        end
        return r;
    endfunction

    // Lowest set bit at or above p, otherwise wrap to lowest set bit overall.
    function automatic logic [W-1:0] sel(input logic [N-1:0] v, input logic [W-1:0] p);
        logic [N-1:0] hi;
        hi = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hi[i] = v[i] && (i >= 32'(p));
        end
        return (hi != '0) ? lowest(hi) : lowest(v);
    endfunction

    function automatic logic single(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        zero_err_d  = 1'b0;
        rem         = '0;
        ptr_nxt     = ptr_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req != '0) begin
                        pend_d      = req;
                        idx_d       = sel(req, ptr_q);
                        out_valid_d = 1'b1;
                        out_last_d  = single(req);
                        state_d     = DRAIN;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    rem    = pend_q & ~(ONE << idx_q);
                    pend_d = rem;
                    if (MODE != 0) begin
                        ptr_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + W'(1);
                    end else begin
                        ptr_nxt = '0;
                    end
                    ptr_d = ptr_nxt;
                    if (rem != '0) begin
                        idx_d      = sel(rem, ptr_nxt);
                        out_last_d = single(rem);
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            ptr_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            zero_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            zero_err_q  <= zero_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign idx       = idx_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_prio_enc_seq.sv
// tb_prio_enc_seq
//   Directed bench for prio_enc_seq. Three instances: fixed priority N=8,
//   round-robin N=8, round-robin N=5. Inputs change #1 after each rising edge
//   and outputs are checked at the same point.
module tb_prio_enc_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req8 = '0;
    logic [4:0] req5 = '0;
    logic       rv0 = 1'b0, rv1 = 1'b0, rv2 = 1'b0;
    logic       out_ready = 1'b0;

    logic       rdy0, rdy1, rdy2;
    logic [2:0] idx0, idx1, idx2;
    logic       ov0, ov1, ov2;
    logic       ol0, ol1, ol2;
    logic       ze0, ze1, ze2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prio_enc_seq #(.N(8), .W(3), .MODE(0)) u_fix (
        .clk(clk), .rst(rst), .req(req8), .req_valid(rv0), .req_ready(rdy0),
        .idx(idx0), .out_valid(ov0), .out_ready(out_ready), .out_last(ol0), .zero_err(ze0)
    );

    prio_enc_seq #(.N(8), .W(3), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req(req8), .req_valid(rv1), .req_ready(rdy1),
        .idx(idx1), .out_valid(ov1), .out_ready(out_ready), .out_last(ol1), .zero_err(ze1)
    );

    prio_enc_seq #(.N(5), .W(3), .MODE(1)) u_rr5 (
        .clk(clk), .rst(rst), .req(req5), .req_valid(rv2), .req_ready(rdy2),
        .idx(idx2), .out_valid(ov2), .out_ready(out_ready), .out_last(ol2), .zero_err(ze2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        tests++; if (ov0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", ov0); end
        tests++; if (idx0 !== 3'd0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", idx0); end
        tests++; if (ze0 !== 1'b0) begin fails++; $display("FAIL reset_zero_err got=%0b exp=0", ze0); end
        tests++; if (ol0 !== 1'b0) begin fails++; $display("FAIL reset_out_last got=%0b exp=0", ol0); end
        tests++; if ({rdy0, rdy1, rdy2} !== 3'b111) begin fails++; $display("FAIL reset_req_ready got=%b exp=111", {rdy0, rdy1, rdy2}); end
    endtask

    task automatic test_fixed_two();
        out_ready = 1'b1;
        req8 = 8'h81; rv0 = 1'b1;
        step();
        rv0 = 1'b0;
        tests++; if ({ov0, idx0, ol0} !== {1'b1, 3'd0, 1'b0}) begin fails++; $display("FAIL fix81_first got v=%0b i=%0d l=%0b exp v=1 i=0 l=0", ov0, idx0, ol0); end
        tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL fix81_ready got=%0b exp=0", rdy0); end
        step();
        tests++; if ({ov0, idx0, ol0} !== {1'b1, 3'd7, 1'b1}) begin fails++; $display("FAIL fix81_second got v=%0b i=%0d l=%0b exp v=1 i=7 l=1", ov0, idx0, ol0); end
        step();
        tests++; if ({ov0, ol0, rdy0} !== 3'b001) begin fails++; $display("FAIL fix81_done got v=%0b l=%0b r=%0b exp v=0 l=0 r=1", ov0, ol0, rdy0); end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        req8 = 8'h0C; rv0 = 1'b1;
        step();
        rv0 = 1'b0;
        req8 = 8'hFF;
        rv0 = 1'b1;  // must be ignored while draining
        for (int k = 0; k < 3; k++) begin
            tests++; if ({ov0, idx0, ol0, rdy0} !== {1'b1, 3'd2, 1'b0, 1'b0}) begin
                fails++; $display("FAIL hold_%0d got v=%0b i=%0d l=%0b r=%0b exp v=1 i=2 l=0 r=0", k, ov0, idx0, ol0, rdy0);
            end
            step();
        end
        rv0 = 1'b0;
        out_ready = 1'b1;
        tests++; if ({ov0, idx0} !== {1'b1, 3'd2}) begin fails++; $display("FAIL hold_end got v=%0b i=%0d exp v=1 i=2", ov0, idx0); end
        step();
        tests++; if ({ov0, idx0, ol0} !== {1'b1, 3'd3, 1'b1}) begin fails++; $display("FAIL hold_pop got v=%0b i=%0d l=%0b exp v=1 i=3 l=1", ov0, idx0, ol0); end
        step();
        tests++; if ({ov0, rdy0} !== 2'b01) begin fails++; $display("FAIL hold_done got v=%0b r=%0b exp v=0 r=1", ov0, rdy0); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        req8 = 8'hFF; rv0 = 1'b1;
        step();
        rv0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests++; if ({ov0, idx0, ol0} !== {1'b1, 3'(k), (k == 7)}) begin
                fails++; $display("FAIL b2b_%0d got v=%0b i=%0d l=%0b exp v=1 i=%0d l=%0b", k, ov0, idx0, ol0, k, (k == 7));
            end
            step();
        end
        tests++; if ({ov0, rdy0} !== 2'b01) begin fails++; $display("FAIL b2b_done got v=%0b r=%0b exp v=0 r=1", ov0, rdy0); end
    endtask

    task automatic test_round_robin();
        out_ready = 1'b1;
        req8 = 8'h01; rv1 = 1'b1;
        step();
        rv1 = 1'b0;
        tests++; if ({ov1, idx1, ol1} !== {1'b1, 3'd0, 1'b1}) begin fails++; $display("FAIL rr01 got v=%0b i=%0d l=%0b exp v=1 i=0 l=1", ov1, idx1, ol1); end
        step();
        req8 = 8'h03; rv1 = 1'b1;
        step();
        rv1 = 1'b0;
        tests++; if ({ov1, idx1, ol1} !== {1'b1, 3'd1, 1'b0}) begin fails++; $display("FAIL rr03_first got v=%0b i=%0d l=%0b exp v=1 i=1 l=0", ov1, idx1, ol1); end
        step();
        tests++; if ({ov1, idx1, ol1} !== {1'b1, 3'd0, 1'b1}) begin fails++; $display("FAIL rr03_second got v=%0b i=%0d l=%0b exp v=1 i=0 l=1", ov1, idx1, ol1); end
        step();
        tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL rr03_done got v=%0b exp v=0", ov1); end
        // ptr is now 1, so bit 1 goes first again
        req8 = 8'h03; rv1 = 1'b1;
        step();
        rv1 = 1'b0;
        tests++; if ({ov1, idx1} !== {1'b1, 3'd1}) begin fails++; $display("FAIL rr_ptr1 got v=%0b i=%0d exp v=1 i=1", ov1, idx1); end
        step();
        step();
        // ptr is 1 again; 0x81 must start at 7
        req8 = 8'h81; rv1 = 1'b1;
        step();
        rv1 = 1'b0;
        tests++; if ({ov1, idx1, ol1} !== {1'b1, 3'd7, 1'b0}) begin fails++; $display("FAIL rr81_first got v=%0b i=%0d l=%0b exp v=1 i=7 l=0", ov1, idx1, ol1); end
        step();
        tests++; if ({ov1, idx1, ol1} !== {1'b1, 3'd0, 1'b1}) begin fails++; $display("FAIL rr81_wrap got v=%0b i=%0d l=%0b exp v=1 i=0 l=1", ov1, idx1, ol1); end
        step();
    endtask

    task automatic test_zero();
        req8 = 8'h00; rv0 = 1'b1;
        step();
        rv0 = 1'b0;
        tests++; if ({ze0, ov0, rdy0} !== 3'b101) begin fails++; $display("FAIL zero_pulse got z=%0b v=%0b r=%0b exp z=1 v=0 r=1", ze0, ov0, rdy0); end
        step();
        tests++; if ({ze0, ov0, rdy0} !== 3'b001) begin fails++; $display("FAIL zero_clear got z=%0b v=%0b r=%0b exp z=0 v=0 r=1", ze0, ov0, rdy0); end
    endtask

    task automatic test_n5_wrap_reset();
        out_ready = 1'b1;
        req5 = 5'b10001; rv2 = 1'b1;
        step();
        rv2 = 1'b0;
        tests++; if ({ov2, idx2, ol2} !== {1'b1, 3'd0, 1'b0}) begin fails++; $display("FAIL n5_first got v=%0b i=%0d l=%0b exp v=1 i=0 l=0", ov2, idx2, ol2); end
        step();
        tests++; if ({ov2, idx2, ol2} !== {1'b1, 3'd4, 1'b1}) begin fails++; $display("FAIL n5_second got v=%0b i=%0d l=%0b exp v=1 i=4 l=1", ov2, idx2, ol2); end
        step();
        tests++; if (ov2 !== 1'b0) begin fails++; $display("FAIL n5_done got v=%0b exp v=0", ov2); end
        // ptr wrapped to 0, so bit 0 leads
        rv2 = 1'b1;
        step();
        rv2 = 1'b0;
        tests++; if ({ov2, idx2} !== {1'b1, 3'd0}) begin fails++; $display("FAIL n5_wrap got v=%0b i=%0d exp v=1 i=0", ov2, idx2); end
        step();
        tests++; if ({ov2, idx2} !== {1'b1, 3'd4}) begin fails++; $display("FAIL n5_mid got v=%0b i=%0d exp v=1 i=4", ov2, idx2); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if ({ov2, ol2, idx2} !== {1'b0, 1'b0, 3'd0}) begin fails++; $display("FAIL n5_rst got v=%0b l=%0b i=%0d exp v=0 l=0 i=0", ov2, ol2, idx2); end
        step();
        tests++; if ({ov2, rdy2} !== 2'b01) begin fails++; $display("FAIL n5_rst_idle got v=%0b r=%0b exp v=0 r=1", ov2, rdy2); end
        // reset returned ptr to 0 (it was 1 before reset)
        rv2 = 1'b1;
        step();
        rv2 = 1'b0;
        tests++; if ({ov2, idx2} !== {1'b1, 3'd0}) begin fails++; $display("FAIL n5_ptr_rst got v=%0b i=%0d exp v=1 i=0", ov2, idx2); end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_fixed_two();
        test_hold();
        test_back_to_back();
        test_round_robin();
        test_zero();
        test_n5_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
